// File: rtl/gf2m_pkg.sv
// GF(2^16) field constants and the coefficient square-root map used by the splitter,
// squarer and multiplier. State encoding for the splitter lives here too.
package gf2m_pkg;

  localparam int GF_M = 16;
  // x^16 + x^5 + x^3 + x^2 + 1
  localparam logic [GF_M:0] GF_POLY = 17'h1002D;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } split_state_e;

  function automatic logic [GF_M-1:0] gf_sq(input logic [GF_M-1:0] a);
    logic [2*GF_M-2:0] w;
    w = '0;
    for (int i = 0; i < GF_M; i++) w[2*i] = a[i];
    for (int b = 2*GF_M-2; b >= GF_M; b--) begin
      if (w[b]) w[b -: GF_M+1] = w[b -: GF_M+1] ^ GF_POLY;
    end
    return w[GF_M-1:0];
  endfunction

  // sqrt(a) = a^(2^(M-1)): squaring M-1 times walks the Frobenius cycle back to the root.
  function automatic logic [GF_M-1:0] gf_sqrt(input logic [GF_M-1:0] a);
    logic [GF_M-1:0] r;
    r = a;
    for (int i = 0; i < GF_M-1; i++) r = gf_sq(r);
    return r;
  endfunction

  function automatic logic [GF_M-1:0][GF_M-1:0] build_sqrt_mat();
    logic [GF_M-1:0][GF_M-1:0] mat;
    logic [GF_M-1:0] col;
    mat = '0;
    for (int c = 0; c < GF_M; c++) begin
      col = gf_sqrt(GF_M'(1) << c);
      for (int r = 0; r < GF_M; r++) mat[r][c] = col[r];
    end
    return mat;
  endfunction

  // SQRT_MAT[r][c] = 1 when input bit c contributes to output bit r.
  localparam logic [GF_M-1:0][GF_M-1:0] SQRT_MAT = build_sqrt_mat();

endpackage

// File: rtl/gf_sqrt_lane.sv
// One-coefficient GF(2^M) square root as a fixed XOR matrix (purely combinational).
module gf_sqrt_lane
  import gf2m_pkg::*;
(
  input  logic [GF_M-1:0] coef_i,
  output logic [GF_M-1:0] root_o
);

  always_comb begin
    root_o = '0;
    for (int r = 0; r < GF_M; r++) root_o[r] = ^(coef_i & SQRT_MAT[r]);
  end

endmodule

// File: rtl/split_poly_lanes.sv
// Splits T(x) into T0, T1 with T = T0^2 + x*T1^2, LANES coefficient roots per cycle.
// Optional macro SPLIT_ZERO_FLAG_EN adds the t0_zero/t1_zero fragment zero flags.
module split_poly_lanes
  import gf2m_pkg::*;
#(
  parameter int M     = GF_M,
  parameter int N     = 9,
  parameter int LANES = 1
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     start,
  input  logic [N*M-1:0]           poly_in,
  output logic                     busy,
  output logic [((N+1)/2)*M-1:0]   first_fragment_out,
  output logic [(N/2)*M-1:0]       second_fragment_out,
  output logic                     split_done
`ifdef SPLIT_ZERO_FLAG_EN
  ,
  output logic                     t0_zero,
  output logic                     t1_zero
`endif
);

  localparam int N0   = (N + 1) / 2;
  localparam int N1   = N / 2;
  localparam int ITER = (N + LANES - 1) / LANES;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int SW   = ITER * LANES * M;

  split_state_e     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    shreg_q, shreg_d;
  logic [N0*M-1:0]  frag0_q, frag0_d;
  logic [N1*M-1:0]  frag1_q, frag1_d;
  logic [M-1:0]     root [LANES];
  logic             accept;
  logic             last;

  assign accept = (state_q == S_IDLE) && start;
  assign last   = (cnt_q == CW'(ITER - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gf_sqrt_lane u_lane (
      .coef_i (shreg_q[l*M +: M]),
      .root_o (root[l])
    );
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    split_done = 1'b0;
    case (state_q)
      S_RUN:   busy       = 1'b1;
      S_DONE:  split_done = 1'b1;
      default: ;
    endcase
  end

  // Coefficient i is always handled in iteration i/LANES by lane i%LANES, so the
  // write decode is static and lanes past N in the last iteration never match.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    frag0_d = frag0_q;
    frag1_d = frag1_q;
    if (accept) begin
      cnt_d   = '0;
      shreg_d = SW'(poly_in);
      frag0_d = '0;
      frag1_d = '0;
    end else if (state_q == S_RUN) begin
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      shreg_d = shreg_q >> (LANES * M);
      for (int i = 0; i < N; i++) begin
        if (cnt_q == CW'(i / LANES)) begin
          if (i % 2 == 0) frag0_d[(i/2)*M +: M] = root[i % LANES];
          else            frag1_d[(i/2)*M +: M] = root[i % LANES];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      frag0_q <= '0;
      frag1_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      frag0_q <= frag0_d;
      frag1_q <= frag1_d;
    end
  end

  assign first_fragment_out  = frag0_q;
  assign second_fragment_out = frag1_q;

`ifdef SPLIT_ZERO_FLAG_EN
  logic t0_zero_q, t1_zero_q;

  // Loaded on the final RUN edge so the flags are valid alongside split_done.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      t0_zero_q <= 1'b0;
      t1_zero_q <= 1'b0;
    end else if (accept) begin
      t0_zero_q <= 1'b0;
      t1_zero_q <= 1'b0;
    end else if (state_q == S_RUN && last) begin
      t0_zero_q <= (frag0_d == '0);
      t1_zero_q <= (frag1_d == '0);
    end
  end

  assign t0_zero = t0_zero_q;
  assign t1_zero = t1_zero_q;
`endif

endmodule
